// File: rtl/timer_pkg.sv
// Shared types and default widths for the loadable down-counter timer.
// Imported by the timer top and its prescaler.
package timer_pkg;

  localparam int WIDTH_D      = 4;
  localparam int PRESCALE_W_D = 8;
  localparam int WRAP_W_D     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler for the down-counter timer: emits a tick every div+1
// enabled cycles, restarting from zero on clear.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;

  assign tick = en && (cnt_q == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with prescaler, terminal-count pulse,
// done handshake and optional auto-reload with saturating wrap count.
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int WIDTH      = WIDTH_D,
  parameter int PRESCALE_W = PRESCALE_W_D,
  parameter int WRAP_W     = WRAP_W_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  start,
  input  logic                  stop,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tc,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [WRAP_W-1:0]     wraps
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t                state_q;
  state_t                state_d;
  logic [WIDTH-1:0]      count_q;
  logic [WIDTH-1:0]      reload_q;
  logic [WRAP_W-1:0]     wraps_q;
  logic [PRESCALE_W-1:0] div_q;
  logic                  auto_q;
  logic                  tc_q;
  logic                  tick;

  logic load_acc;
  logic start_acc;
  logic zero_start;
  logic stop_acc;
  logic dec;
  logic term_rl;
  logic term_end;

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clear(start_acc | stop_acc),
    .en   (state_q == RUN),
    .div  (div_q),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_acc   = 1'b0;
    start_acc  = 1'b0;
    zero_start = 1'b0;
    stop_acc   = 1'b0;
    dec        = 1'b0;
    term_rl    = 1'b0;
    term_end   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          load_acc = 1'b1;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        // load beats start; stop beats start
        if (load_valid) begin
          load_acc = 1'b1;
        end else if (start && !stop) begin
          start_acc = 1'b1;
          if (count_q == '0) begin
            zero_start = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          stop_acc = 1'b1;
          state_d  = ARMED;
        end else if (tick) begin
          if (count_q != ONE) begin
            dec = 1'b1;
          end else if (auto_q) begin
            term_rl = 1'b1;
          end else begin
            term_end = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      reload_q <= '0;
      wraps_q  <= '0;
      div_q    <= '0;
      auto_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= zero_start | term_rl | term_end;
      unique case (1'b1)
        load_acc: count_q <= load_value;
        dec:      count_q <= count_q - ONE;
        term_rl:  count_q <= reload_q;
        term_end: count_q <= '0;
        default:  count_q <= count_q;
      endcase
      if (load_acc) begin
        reload_q <= load_value;
      end
      if (load_acc) begin
        wraps_q <= '0;
      end else if (term_rl && (wraps_q != '1)) begin
        wraps_q <= wraps_q + WRAP_W'(1);
      end
      // run configuration is frozen from start until the next start
      if (start_acc) begin
        div_q  <= prescale;
        auto_q <= auto_reload;
      end
    end
  end

  assign count      = count_q;
  assign tc         = tc_q;
  assign wraps      = wraps_q;
  assign busy       = (state_q == RUN);
  assign done_valid = (state_q == DONE);
  assign load_ready = (state_q == IDLE) || (state_q == ARMED);

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable down-counter/timer that complements the team's free-running up counter. Software or a controller loads a start value through a valid/ready handshake and starts the countdown. The counter then decrements once every (prescale+1) clock cycles and flags terminal count. Completion is reported through a done valid/ready handshake, with optional auto-reload for periodic operation. It sits beside the up counter in the timing/utility blocks.

Parameters:
WIDTH, 4, bit width of count and load value
PRESCALE_W, 8, bit width of prescale divider input
WRAP_W, 4, bit width of saturating auto-reload wrap counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
load_valid  input  1  load request
load_ready  output  1  load can be accepted
load_value  input  WIDTH  countdown start value
auto_reload  input  1  reload on terminal count instead of finishing; sampled at start
prescale  input  PRESCALE_W  decrement every prescale+1 cycles; sampled at start
start  input  1  begin/resume countdown
stop  input  1  pause countdown
count  output  WIDTH  current count value
busy  output  1  high in RUN
tc  output  1  one-cycle terminal-count pulse
done_valid  output  1  completion event pending
done_ready  input  1  completion acknowledged
wraps  output  WRAP_W  number of auto-reloads, saturating

Behaviour:
- Reset (rst=0, asynchronous, any state): state=IDLE; count=0, reload=0, prescaler=0, wraps=0, tc=0, busy=0, done_valid=0, load_ready=1. The reset takes effect immediately, without a clock edge.
- States are IDLE, ARMED, RUN and DONE. All outputs are registered or decoded from state.
- load_ready=1 in IDLE and ARMED and 0 in RUN and DONE. A load is accepted on load_valid&&load_ready.
  - count<=load_value, reload<=load_value, wraps<=0, state<=ARMED.
- ARMED:
  - load takes priority over start.
  - stop takes priority over start, so start&&stop leaves the state unchanged.
  - On start: capture prescale and auto_reload, clear the prescaler.
  - If count==0, go to DONE and pulse tc on the next cycle. Otherwise go to RUN.
- RUN:
  - The prescaler increments each cycle. When it equals the captured prescale, it clears and a tick occurs.
  - On a tick with count>1: count<=count-1.
  - On a tick with count==1 (terminal), tc<=1 for exactly one cycle.
    - If auto_reload: count<=reload, wraps<=wraps+1 (saturating at all-ones), stay in RUN.
    - Otherwise: count<=0, state<=DONE.
  - stop: state<=ARMED, count held, prescaler cleared. A later start resumes from the held count.
  - start and load are ignored in RUN.
- Latency: with prescale=0, start accepted at edge k gives count=N-j after edge k+j. Terminal occurs at edge k+N, with tc high and count 0 (non-reload) in the following cycle.
- DONE:
  - done_valid=1, held until done_ready.
  - On done_ready: state<=IDLE, done_valid<=0 the next cycle, count stays 0.
  - done_ready outside DONE is ignored.
- Captured prescale and auto_reload do not change mid-run. Input changes take effect only at the next start.
- Width rules:
  - count never underflows; 0 is only reached via a terminal tick or a load of 0.
  - The prescaler compare is an equality test on PRESCALE_W bits.

Decomposition:
- Shared package timer_pkg holds the state typedef (IDLE, ARMED, RUN, DONE) and the default width constants.
- One sub-module, tick_prescaler, has inputs clk, rst, clear, en and div[PRESCALE_W] and output tick. It implements the prescaler counter and equality compare.
- The FSM, count, reload and wraps logic stay in down_counter_timer.

Test Plan:
1. Load 5, prescale=0, auto_reload=0, start -> count 4,3,2,1,0 on successive cycles. Then tc=1 for one cycle with count=0, done_valid=1 held until done_ready, then IDLE with load_ready=1.
2. Load 3, prescale=2, start -> count decrements every 3 cycles, tc 9 cycles after start. Changing prescale to 0 mid-run has no effect.
3. Load 2, prescale=0, auto_reload=1, start -> count 1,2,1,2 with tc every 2 cycles and wraps 1,2,3. Run until wraps saturates at 15 and stays 15. Stop -> busy=0 and count holds. Start -> resumes from the held value.
4. Load 0 then start -> DONE next cycle, tc pulse, count=0. In ARMED, load_valid+start in the same cycle -> load wins and state stays ARMED. start+stop together -> no change.
5. Assert rst=0 mid-RUN (count=7) between clock edges -> count=0, busy=0, tc=0, done_valid=0, wraps=0 immediately. After release, load_ready=1.
6. In RUN, load_valid=1 -> load_ready=0 and count unaffected. In DONE with done_ready=0 for 10 cycles -> done_valid stays 1 and tc does not repeat.
